// File: rtl/instr_mem_loader.sv
//------------------------------------------------------------------------------
// instr_mem_loader: boot-time byte-stream writer for instruction memory.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_mem_loader #(
  parameter int XLEN           = 32,
  parameter int MEM_SIZE_WORDS = 1024,
  parameter int BASE_ADDR      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            wr_en,
  output logic [XLEN-1:0] wr_addr,
  output logic [XLEN-1:0] wr_data,
  output logic            core_hold,
  output logic            done,
  output logic            error,
  output logic [XLEN-1:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      byte_idx;
  logic [23:0]     partial;
  logic [XLEN-1:0] word_cnt;
  logic [XLEN-1:0] word_idx;
  logic            accept;
  logic            last_byte;
  logic [XLEN-1:0] full_word;

  assign in_ready  = (state == S_LEN) || (state == S_DATA) || (state == S_ERROR);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_idx == 2'd3);
  // The fourth byte completes the word directly from the bus this cycle.
  assign full_word = {in_data, partial};

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        if (last_byte) begin
          if (full_word > XLEN'(MEM_SIZE_WORDS)) state_next = S_ERROR;
          else if (full_word == '0)              state_next = S_DONE;
          else                                   state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte && (word_idx == word_cnt - XLEN'(1))) state_next = S_DONE;
      end
      S_DONE: begin
        if (start) state_next = S_LEN;
      end
      S_ERROR: begin
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      byte_idx      <= 2'd0;
      partial       <= 24'd0;
      word_cnt      <= '0;
      word_idx      <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      core_hold     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      state <= state_next;
      wr_en <= 1'b0;
      if ((state_next == S_LEN) && (state != S_LEN)) begin
        byte_idx      <= 2'd0;
        partial       <= 24'd0;
        word_idx      <= '0;
        done          <= 1'b0;
        error         <= 1'b0;
        core_hold     <= 1'b1;
        words_written <= '0;
      end else if (accept && ((state == S_LEN) || (state == S_DATA))) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    partial[7:0]   <= in_data;
          2'd1:    partial[15:8]  <= in_data;
          2'd2:    partial[23:16] <= in_data;
          default: ;
        endcase
        if (byte_idx == 2'd3) begin
          if (state == S_LEN) begin
            word_cnt <= full_word;
          end else begin
            wr_en         <= 1'b1;
            wr_data       <= full_word;
            wr_addr       <= XLEN'(BASE_ADDR) + (word_idx << 2);
            words_written <= words_written + XLEN'(1);
            word_idx      <= word_idx + XLEN'(1);
          end
        end
      end
      if ((state_next == S_DONE) && (state != S_DONE)) begin
        done      <= 1'b1;
        core_hold <= 1'b0;
      end
      if ((state_next == S_ERROR) && (state != S_ERROR)) begin
        error <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
//------------------------------------------------------------------------------
// tb_instr_mem_loader: directed self-checking bench for instr_mem_loader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [31:0] words_written;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0]  stim[$];
  int          acc[$];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  instr_mem_loader #(
    .XLEN(32),
    .MEM_SIZE_WORDS(4),
    .BASE_ADDR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .core_hold(core_hold),
    .done(done),
    .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives stim[] from a negedge; acc[] receives the posedge number of each acceptance.
  task automatic send_stream(input int gap);
    acc.delete();
    foreach (stim[i]) begin
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = stim[i];
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        check("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
      acc.push_back(cyc + 1);
      @(negedge clk);
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (gap) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic check_two_words(input string tag);
    check({tag, "_wcount"}, wq_addr.size(), 32'd2);
    if (wq_addr.size() >= 2 && acc.size() == 12) begin
      check({tag, "_addr0"}, wq_addr[0], 32'h0000_0000);
      check({tag, "_data0"}, wq_data[0], 32'h0010_0513);
      check({tag, "_lat0"},  wq_cyc[0],  acc[7]);
      check({tag, "_addr1"}, wq_addr[1], 32'h0000_0004);
      check({tag, "_data1"}, wq_data[1], 32'h0000_006F);
      check({tag, "_lat1"},  wq_cyc[1],  acc[11]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_core_hold", core_hold, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_written, 0);
    check("rst_wr_addr", wr_addr, 0);

    // Two-word image, back to back
    clear_writes();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
             8'h6F, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("b2b_first_done", done, 1);
    check("b2b_first_hold", core_hold, 0);
    check("b2b_last_wr_en", wr_en, 1);
    repeat (3) @(negedge clk);
    check_two_words("b2b");
    if (wq_cyc.size() >= 2) check("b2b_spacing", wq_cyc[1] - wq_cyc[0], 32'd4);
    check("b2b_done", done, 1);
    check("b2b_hold", core_hold, 0);
    check("b2b_words", words_written, 2);
    check("b2b_ready", in_ready, 0);

    // Reload with gaps between every byte
    clear_writes();
    pulse_start();
    check("reload_hold", core_hold, 1);
    check("reload_done", done, 0);
    check("reload_words", words_written, 0);
    send_stream(3);
    repeat (3) @(negedge clk);
    check_two_words("gap");
    check("gap_done", done, 1);
    check("gap_words", words_written, 2);

    // Oversized length goes to ERROR and drains
    clear_writes();
    pulse_start();
    stim = '{8'h05, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("err_flag", error, 1);
    check("err_hold", core_hold, 1);
    check("err_ready", in_ready, 1);
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(i * 7 + 1));
    send_stream(0);
    check("err_drained", acc.size(), 20);
    check("err_ready_after", in_ready, 1);
    check("err_no_writes", wq_addr.size(), 0);
    check("err_done", done, 0);
    pulse_start();
    check("err_clear", error, 0);
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(0);
    repeat (2) @(negedge clk);
    check("rec_wcount", wq_addr.size(), 1);
    if (wq_addr.size() >= 1) begin
      check("rec_addr", wq_addr[0], 32'h0000_0000);
      check("rec_data", wq_data[0], 32'hDDCC_BBAA);
    end
    check("rec_done", done, 1);
    check("rec_error", error, 0);
    check("rec_words", words_written, 1);

    // Zero-length image
    clear_writes();
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(0);
    check("zero_done", done, 1);
    check("zero_hold", core_hold, 0);
    check("zero_wr_en", wr_en, 0);
    check("zero_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    check("zero_no_writes", wq_addr.size(), 0);
    check("zero_words", words_written, 0);

    // Reset in the middle of a three-word load
    pulse_start();
    stim = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66};
    send_stream(0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    rst      = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_addr", wr_addr, 0);
    check("mid_rst_data", wr_data, 0);
    check("mid_rst_hold", core_hold, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    check("mid_rst_words", words_written, 0);
    clear_writes();
    repeat (2) @(negedge clk);
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h37, 8'h01, 8'h00, 8'h00};
    send_stream(0);
    repeat (2) @(negedge clk);
    check("fresh_wcount", wq_addr.size(), 1);
    if (wq_addr.size() >= 1) begin
      check("fresh_addr", wq_addr[0], 32'h0000_0000);
      check("fresh_data", wq_data[0], 32'h0000_0137);
    end
    check("fresh_words", words_written, 1);
    check("fresh_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
